// File: rtl/req_pend_collector_pkg.sv
// Shared encoder definitions (package cdp_pkg): default request width, index
// width and the encoder's index-to-bit mapping.
package cdp_pkg;

  localparam int N_REQ_DEF = 4;

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Index 0 is the MSB (highest priority); the mapping is its own inverse.
  function automatic int idx2bit(input int idx, input int n);
    return n - 1 - idx;
  endfunction

endpackage

// File: rtl/req_pend_collector_sync_ff.sv
// Single-bit multi-flop synchroniser with asynchronous active-low reset.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/req_pend_collector.sv
// Request pending collector feeding the priority encoder. Define REQ_EDGE_EN for
// rising-edge set events with overflow flags; otherwise requests act as levels.
module req_pend_collector
  import cdp_pkg::*;
#(
  parameter  int N_REQ       = N_REQ_DEF,
  parameter  int SYNC_STAGES = 2,
  localparam int IDX_W       = idx_width(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_in,
  input  logic             mask_we,
  input  logic [N_REQ-1:0] mask_wdata,
  input  logic             ack,
  input  logic [IDX_W-1:0] ack_idx,
  input  logic             ovf_clr,
  output logic [N_REQ-1:0] pend_out,
  output logic             any_pend,
  output logic [N_REQ-1:0] ovf,
  output logic             ack_err
);

  logic [N_REQ-1:0] sync_lvl;
  logic [N_REQ-1:0] set_ev;
  logic [N_REQ-1:0] ack_vec;
  logic [N_REQ-1:0] pend;
  logic [N_REQ-1:0] pend_nxt;
  logic [N_REQ-1:0] mask;
  logic [N_REQ-1:0] ovf_q;
  logic [N_REQ-1:0] ovf_nxt;
  logic             ack_err_nxt;

  for (genvar i = 0; i < N_REQ; i++) begin : g_line
    sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (req_in[i]),
      .q     (sync_lvl[i])
    );
    assign ack_vec[i] = ack && (ack_idx == IDX_W'(idx2bit(i, N_REQ)));
  end

`ifdef REQ_EDGE_EN
  logic [N_REQ-1:0] sync_dly;
  logic [N_REQ-1:0] ovf_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_dly <= '0;
    else        sync_dly <= sync_lvl;
  end

  assign set_ev = sync_lvl & ~sync_dly;

  // A set event beats a same-cycle ack; it only overflows a bit left pending.
  always_comb begin
    pend_nxt    = (pend & ~ack_vec) | set_ev;
    ovf_set     = set_ev & pend & ~ack_vec;
    ovf_nxt     = ovf_clr ? ovf_set : (ovf_q | ovf_set);
    ack_err_nxt = ack && ~|(ack_vec & (pend | set_ev));
  end
`else
  logic unused_ovf_clr;

  assign set_ev         = sync_lvl;
  assign unused_ovf_clr = ovf_clr;

  // The ack wins over a held level so the line drops for one cycle, then re-pends.
  always_comb begin
    pend_nxt    = (pend | set_ev) & ~ack_vec;
    ovf_nxt     = '0;
    ack_err_nxt = ack && ~|(ack_vec & pend);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend    <= '0;
      mask    <= '0;
      ovf_q   <= '0;
      ack_err <= 1'b0;
    end else begin
      pend    <= pend_nxt;
      ovf_q   <= ovf_nxt;
      ack_err <= ack_err_nxt;
      if (mask_we) mask <= mask_wdata;
    end
  end

  assign pend_out = pend & ~mask;
  assign any_pend = |pend_out;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_req_pend_collector.sv
// Directed plus randomized bench for req_pend_collector against a delay-line and
// per-bit rule model; honours REQ_EDGE_EN the same way as the design.
module tb_req_pend_collector;

  localparam int N = 4;
  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req_in;
  logic       mask_we;
  logic [3:0] mask_wdata;
  logic       ack;
  logic [1:0] ack_idx;
  logic       ovf_clr;
  logic [3:0] pend_out;
  logic       any_pend;
  logic [3:0] ovf;
  logic       ack_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] m_hist[$];
  logic [3:0] m_prev, m_pend, m_mask, m_ovf;
  logic       m_err;

  req_pend_collector #(.N_REQ(N), .SYNC_STAGES(S)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_in     (req_in),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .ack        (ack),
    .ack_idx    (ack_idx),
    .ovf_clr    (ovf_clr),
    .pend_out   (pend_out),
    .any_pend   (any_pend),
    .ovf        (ovf),
    .ack_err    (ack_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hist = {};
    for (int k = 0; k < S; k++) m_hist.push_back(4'b0);
    m_prev = '0; m_pend = '0; m_mask = '0; m_ovf = '0; m_err = 1'b0;
  endtask

  // One clock edge of the model, using the inputs present at that edge.
  task automatic model_edge();
    logic [3:0] lvl, ev, np, oset;
    logic acked;
    int b;
    lvl  = m_hist[0];
`ifdef REQ_EDGE_EN
    ev   = lvl & ~m_prev;
`else
    ev   = lvl;
`endif
    b    = N - 1 - int'(ack_idx);
    np   = m_pend;
    oset = '0;
    for (int i = 0; i < N; i++) begin
      acked = ack && (i == b);
`ifdef REQ_EDGE_EN
      if (ev[i]) begin
        if (m_pend[i] && !acked) oset[i] = 1'b1;
        np[i] = 1'b1;
      end else if (acked) np[i] = 1'b0;
`else
      np[i] = acked ? 1'b0 : (m_pend[i] | ev[i]);
`endif
    end
`ifdef REQ_EDGE_EN
    m_err = ack && !(m_pend[b] || ev[b]);
    m_ovf = ovf_clr ? oset : (m_ovf | oset);
`else
    m_err = ack && !m_pend[b];
`endif
    if (mask_we) m_mask = mask_wdata;
    m_pend = np;
    m_prev = lvl;
    void'(m_hist.pop_front());
    m_hist.push_back(req_in);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pend_out"}, pend_out, m_pend & ~m_mask);
    chk({tag, ".any_pend"}, any_pend, |(m_pend & ~m_mask));
    chk({tag, ".ovf"},      ovf,      m_ovf);
    chk({tag, ".ack_err"},  ack_err,  m_err);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (rst_n) model_edge();
    else       model_reset();
    #1;
    check_all(tag);
    mask_we = 1'b0;
    ack     = 1'b0;
    ovf_clr = 1'b0;
  endtask

  task automatic do_ack(input logic [1:0] idx, input string tag);
    ack = 1'b1; ack_idx = idx;
    step(tag);
  endtask

  initial begin
    rst_n = 1'b0; req_in = 4'hF; mask_we = 1'b0; mask_wdata = '0;
    ack = 1'b0; ack_idx = '0; ovf_clr = 1'b0;
    model_reset();
    #2;
    check_all("rst_hold");
    chk("rst.pend_zero", pend_out, 4'h0);
    step("rst_e1");
    step("rst_e2");
    rst_n = 1'b1;
    step("rel_e1");
    step("rel_e2");
    chk("rel_e2.not_yet", pend_out, 4'h0);
    step("rel_e3");
    chk("rel_e3.all_pend", pend_out, 4'hF);

    req_in = 4'h0;
    repeat (3) step("drain");
    for (int k = 0; k < 4; k++) do_ack(2'(k), "clear_all");
    chk("clear_all.empty", pend_out, 4'h0);

    req_in = 4'b0100;
    step("latch_e1");
    req_in = 4'b0000;
    step("latch_e2");
    step("latch_e3");
    chk("latch.bit2", pend_out, 4'b0100);
    step("latch_hold");
    chk("latch.held", pend_out, 4'b0100);
    do_ack(2'd1, "latch_ack");
    chk("latch_ack.cleared", pend_out, 4'b0000);

    mask_we = 1'b1; mask_wdata = 4'b1000;
    step("mask_wr");
    req_in = 4'b1000;
    step("mask_e1");
    req_in = 4'b0000;
    repeat (3) step("mask_wait");
    chk("mask.hidden", pend_out, 4'b0000);
    chk("mask.any_pend", any_pend, 1'b0);
    mask_we = 1'b1; mask_wdata = 4'b0000;
    step("unmask");
    chk("unmask.exposed", pend_out, 4'b1000);
    do_ack(2'd0, "unmask_ack");

    req_in = 4'b0001;
    step("err_e1");
    req_in = 4'b0000;
    step("err_e2");
    step("err_e3");
    do_ack(2'd0, "err_ack");
    chk("err.pulse", ack_err, 1'b1);
    chk("err.unchanged", pend_out, 4'b0001);
    step("err_after");
    chk("err.one_cycle", ack_err, 1'b0);

`ifdef REQ_EDGE_EN
    for (int r = 0; r < 2; r++) begin
      req_in = 4'b0001; step("ovf_rise");
      req_in = 4'b0000; step("ovf_fall");
    end
    repeat (3) step("ovf_wait");
    chk("ovf.set", ovf, 4'b0001);
    ovf_clr = 1'b1;
    step("ovf_clr");
    chk("ovf.cleared", ovf, 4'b0000);
    req_in = 4'b0001;
    step("race_e1");
    step("race_e2");
    ack = 1'b1; ack_idx = 2'd3;
    step("race_e3");
    chk("race.pend_kept", pend_out, 4'b0001);
    chk("race.no_ovf", ovf, 4'b0000);
    chk("race.no_err", ack_err, 1'b0);
    req_in = 4'b0000;
    do_ack(2'd3, "race_clear");
`else
    do_ack(2'd3, "lvl_pre_clear");
    req_in = 4'b0010;
    repeat (3) step("lvl_fill");
    chk("lvl.pend", pend_out[1], 1'b1);
    do_ack(2'd2, "lvl_ack");
    chk("lvl.dropped", pend_out[1], 1'b0);
    step("lvl_repend");
    chk("lvl.repend", pend_out[1], 1'b1);
    chk("lvl.no_ovf", ovf, 4'b0000);
`endif

    req_in = 4'b0010;
    repeat (3) step("midrst_fill");
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("midrst");
    chk("midrst.zero", pend_out, 4'h0);
    step("midrst_hold");
    rst_n = 1'b1;
    step("midrst_e1");
    step("midrst_e2");
    step("midrst_e3");
    chk("midrst.relatch", pend_out, 4'b0010);

    for (int it = 0; it < 400; it++) begin
      req_in     = 4'($urandom);
      mask_we    = ($urandom_range(0, 7) == 0);
      mask_wdata = 4'($urandom);
      ack        = ($urandom_range(0, 2) == 0);
      ack_idx    = 2'($urandom);
      ovf_clr    = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 96) == 0) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("rnd_rst");
        step("rnd_rst_hold");
        rst_n = 1'b1;
      end else begin
        step("rnd");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
